// File: rtl/bip_pkg.sv
// Shared constants and types for the BIP execution controller.
package bip_pkg;

    localparam int OPC_W = 5;
    localparam logic [OPC_W-1:0] HALT_OP = 5'b00000;

    localparam int PC_W  = 11;
    localparam int ACC_W = 16;
    localparam int TR_W  = 27;

    localparam logic [1:0] CMD_RUN   = 2'd0;
    localparam logic [1:0] CMD_STEP  = 2'd1;
    localparam logic [1:0] CMD_HALT  = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bip_trace_fifo.sv
// Show-ahead trace FIFO; drops pushes that find it full (no pop) and latches a sticky overflow flag.
module bip_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 27
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] last_q;
    logic         push_ok;
    logic         pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop_ok  = pop && !clear && !empty;
    assign push_ok = push && !clear && (!full || pop_ok);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
            if (push && !push_ok)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // When drained, keep presenting the last popped entry.
    assign head_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bip_exec_controller.sv
// BIP execution controller: command FSM, CPU clock-enable decode, cycle counter, accumulator-write trace.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | paused / reset; CPU disabled, waiting for RUN or STEP
//   RUN     | free-running; enabled until HALT opcode or HALT command
//   STEP    | single enabled cycle, then back to IDLE (DONE on HALT op)
//   DONE    | program executed HALT; only CLEAR leaves
module bip_exec_controller
    import bip_pkg::*;
#(
    parameter int TR_DEPTH = 16,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    input  logic [1:0]       CMD_CODE,
    output logic             CMD_READY,
    input  logic [OPC_W-1:0] OPCODE,
    input  logic [PC_W-1:0]  PC,
    input  logic             WR_ACC,
    input  logic [ACC_W-1:0] ACC,
    output logic             CPU_EN,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] CYCLES,
    input  logic             TR_RD,
    output logic [TR_W-1:0]  TR_DATA,
    output logic             TR_EMPTY,
    output logic             TR_FULL,
    output logic             TR_OVF
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             cpu_en;
    logic             clear;
    logic             is_halt_op;
    logic             cmd_run;
    logic             cmd_step;
    logic             cmd_halt;
    logic             cmd_clear;
    logic [CNT_W-1:0] cycles_q;
    logic             pend_q;
    logic [PC_W-1:0]  pc_lat_q;

    assign CMD_READY  = 1'b1;
    assign is_halt_op = (OPCODE == HALT_OP);
    assign cmd_run    = CMD_VALID && (CMD_CODE == CMD_RUN);
    assign cmd_step   = CMD_VALID && (CMD_CODE == CMD_STEP);
    assign cmd_halt   = CMD_VALID && (CMD_CODE == CMD_HALT);
    assign cmd_clear  = CMD_VALID && (CMD_CODE == CMD_CLEAR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // CLEAR always wins and holds the CPU off, so the counter and trace restart cleanly.
    always_comb begin
        state_nxt = state;
        cpu_en    = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_clear)
                    clear = 1'b1;
                else if (cmd_run)
                    state_nxt = ST_RUN;
                else if (cmd_step)
                    state_nxt = ST_STEP;
            end
            ST_RUN: begin
                if (cmd_clear) begin
                    clear     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cmd_halt)
                    state_nxt = ST_IDLE;
                else if (is_halt_op)
                    state_nxt = ST_DONE;
                else
                    cpu_en = 1'b1;
            end
            ST_STEP: begin
                if (cmd_clear) begin
                    clear     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cpu_en    = !is_halt_op;
                    state_nxt = is_halt_op ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (cmd_clear) begin
                    clear     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cycles_q <= '0;
        else if (clear)
            cycles_q <= '0;
        else if (cpu_en && !(&cycles_q))
            cycles_q <= cycles_q + CNT_ONE;
    end

    // The push is delayed one cycle so the entry carries the accumulator after the write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_q   <= 1'b0;
            pc_lat_q <= '0;
        end else if (clear) begin
            pend_q   <= 1'b0;
        end else begin
            pend_q <= cpu_en && WR_ACC;
            if (cpu_en && WR_ACC)
                pc_lat_q <= PC;
        end
    end

    bip_trace_fifo #(
        .DEPTH (TR_DEPTH),
        .W     (TR_W)
    ) u_trace_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (clear),
        .push      (pend_q),
        .push_data ({pc_lat_q, ACC}),
        .pop       (TR_RD),
        .head_data (TR_DATA),
        .full      (TR_FULL),
        .empty     (TR_EMPTY),
        .ovf       (TR_OVF)
    );

    assign CPU_EN = cpu_en;
    assign STATE  = state;
    assign CYCLES = cycles_q;

endmodule
